// File: rtl/conv_encoder_k3_if.sv
// conv_encoder_k3_if: bit-in / symbol-out handshake bundle for the K=3 convolutional encoder.
interface conv_encoder_k3_if;
   logic       in_valid;
   logic       in_bit;
   logic       in_last;
   logic       in_ready;
   logic       out_valid;
   logic [1:0] out_pair;
   logic       out_last;
   logic       out_ready;
   modport master (output in_valid, in_bit, in_last, out_ready, input in_ready, out_valid, out_pair, out_last);
   modport slave  (input in_valid, in_bit, in_last, out_ready, output in_ready, out_valid, out_pair, out_last);
endinterface

// File: rtl/conv_encoder_k3.sv
// conv_encoder_k3: rate-1/2 K=3 convolutional encoder with optional 2-bit zero tail per frame.
module conv_encoder_k3 #(
   parameter logic [2:0] G0      = 3'b111,
   parameter logic [2:0] G1      = 3'b101,
   parameter bit         TAIL_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   conv_encoder_k3_if.slave  bus,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, DATA, TAIL1, TAIL2} state_t;
   state_t     st;
   logic [1:0] s;
   logic [1:0] pair;
   logic [2:0] r;
   logic       u;
   logic       slot_free;
   logic       tail;
   logic       accept;
   logic       load;
   logic       end_now;
   always_comb begin
      slot_free    = !bus.out_valid || bus.out_ready;
      tail         = st == TAIL1 || st == TAIL2;
      bus.in_ready = !tail && slot_free;
      accept       = bus.in_valid && bus.in_ready;
      load         = accept || (tail && slot_free);
      u            = !tail && bus.in_bit;
      r            = {u, s};
      pair         = {^(G0 & r), ^(G1 & r)};
      end_now      = accept && bus.in_last && !TAIL_EN;
   end
   assign busy = st != IDLE;
   // Without a tail the last data symbol closes the frame, so the trellis is forced back to 00 here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st            <= IDLE;
         s             <= 2'b00;
         bus.out_valid <= 1'b0;
         bus.out_pair  <= 2'b00;
         bus.out_last  <= 1'b0;
      end else begin
         if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_pair  <= pair;
            bus.out_last  <= end_now || st == TAIL2;
            s             <= end_now ? 2'b00 : {u, s[1]};
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
         if (accept)
            st <= !bus.in_last ? DATA : TAIL_EN ? TAIL1 : IDLE;
         else if (tail && slot_free)
            st <= st == TAIL1 ? TAIL2 : IDLE;
      end
   end
endmodule

// File: tb/tb_conv_encoder_k3.sv
// tb_conv_encoder_k3: directed + random frames on a tailed and an untailed encoder, checked
// against a convolution reference and a symbol-queue occupancy model.
module tb_conv_encoder_k3;
   localparam logic [2:0] G0 = 3'b111;
   localparam logic [2:0] G1 = 3'b101;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   logic sel = 1'b0;
   logic in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic busy_a, busy_b;
   conv_encoder_k3_if ia();
   conv_encoder_k3_if ib();
   assign ia.in_valid  = !sel && in_valid;
   assign ia.in_bit    = in_bit;
   assign ia.in_last   = in_last;
   assign ia.out_ready = sel || out_ready;
   assign ib.in_valid  = sel && in_valid;
   assign ib.in_bit    = in_bit;
   assign ib.in_last   = in_last;
   assign ib.out_ready = !sel || out_ready;
   conv_encoder_k3 #(.G0(G0), .G1(G1), .TAIL_EN(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave), .busy(busy_a));
   conv_encoder_k3 #(.G0(G0), .G1(G1), .TAIL_EN(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave), .busy(busy_b));
   logic       o_ready, o_valid, o_last, o_busy;
   logic [1:0] o_pair;
   assign o_ready = sel ? ib.in_ready  : ia.in_ready;
   assign o_valid = sel ? ib.out_valid : ia.out_valid;
   assign o_pair  = sel ? ib.out_pair  : ia.out_pair;
   assign o_last  = sel ? ib.out_last  : ia.out_last;
   assign o_busy  = sel ? busy_b       : busy_a;

   int         n_chk = 0, n_fail = 0, acc_cnt = 0, pc = 0;
   logic       mv = 1'b0, mlast = 1'b0, active = 1'b0;
   logic [1:0] mpair = 2'b00;
   int         tail_left = 0;
   logic [2:0] exp_q[$];
   logic [1:0] stream_q[$];
   logic [1:0] got[$];
   logic [1:0] t1[6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
   logic [1:0] t4[3] = '{2'b11, 2'b01, 2'b11};

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected symbols come straight from the generator convolution over the (tail-padded) bit list.
   task automatic add_frame(input logic [15:0] bits, input int n);
      logic [17:0] x;
      logic        u, s1, s0, p1, p0, tl;
      int          total;
      tl = !sel;
      x = '0;
      for (int i = 0; i < n; i++) x[i] = bits[i];
      total = n + (tl ? 2 : 0);
      for (int i = 0; i < total; i++) begin
         u  = x[i];
         s1 = (i >= 1) ? x[i-1] : 1'b0;
         s0 = (i >= 2) ? x[i-2] : 1'b0;
         p1 = (G0[2] & u) ^ (G0[1] & s1) ^ (G0[0] & s0);
         p0 = (G1[2] & u) ^ (G1[1] & s1) ^ (G1[0] & s0);
         exp_q.push_back({p1, p0, i == total - 1});
      end
      for (int i = 0; i < n; i++) stream_q.push_back({bits[i], i == n - 1});
   endtask

   task automatic cycle(input int mode);
      logic       sf, eir, acc, ld;
      logic [2:0] e;
      #1;
      rst_n = 1'b1;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (pc % 4 == 0 || pc % 4 == 3) : 1'($urandom % 2);
      pc++;
      in_valid = stream_q.size() > 0 && (mode != 2 || $urandom % 4 != 0);
      in_bit   = in_valid ? stream_q[0][1] : 1'($urandom % 2);
      in_last  = in_valid ? stream_q[0][0] : 1'($urandom % 2);
      @(negedge clk);
      sf  = !mv || out_ready;
      eir = tail_left == 0 && sf;
      chk("in_ready", o_ready, eir);
      chk("out_valid", o_valid, mv);
      chk("busy", o_busy, active);
      if (mv) begin
         chk("out_pair", o_pair, mpair);
         chk("out_last", o_last, mlast);
      end
      if (mv && out_ready) got.push_back(o_pair);
      acc = in_valid && eir;
      ld  = acc || (tail_left > 0 && sf);
      if (ld && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         mv = 1'b1;
         mpair = e[2:1];
         mlast = e[0];
         if (acc) begin
            acc_cnt++;
            tail_left = (in_last && !sel) ? 2 : 0;
            active = !(in_last && sel);
            void'(stream_q.pop_front());
         end else begin
            tail_left--;
            active = tail_left > 0;
         end
      end else if (out_ready) begin
         mv = 1'b0;
      end
      @(posedge clk);
   endtask

   task automatic run(input int mode, input int stop_acc, input int max_cyc);
      int c = 0;
      acc_cnt = 0;
      while (!(stop_acc > 0 ? acc_cnt >= stop_acc : (stream_q.size() == 0 && !active && !mv)) && c < max_cyc) begin
         cycle(mode);
         c++;
      end
      chk("timeout", 3'(c < max_cyc), 3'd1);
   endtask

   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      mv = 1'b0;
      active = 1'b0;
      tail_left = 0;
      stream_q.delete();
      exp_q.delete();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", o_valid, 1'b0);
      chk("rst_out_pair", o_pair, 2'b00);
      chk("rst_out_last", o_last, 1'b0);
      chk("rst_busy_a", busy_a, 1'b0);
      chk("rst_busy_b", busy_b, 1'b0);
      @(posedge clk);
      // Basic tailed frame 1,0,1,1 against the hand-derived symbol list.
      got.delete();
      add_frame(16'b1101, 4);
      run(0, 0, 50);
      chk("t1_count", 3'(got.size()), 3'd6);
      for (int i = 0; i < 6 && i < got.size(); i++) chk("t1_sym", got[i], t1[i]);
      add_frame(16'b1101, 4);
      run(1, 0, 80);
      // Back-to-back frames; in_valid stays high through both tails.
      add_frame(16'b1, 1);
      add_frame(16'b11, 2);
      run(0, 0, 50);
      add_frame(16'b1, 1);
      add_frame(16'b11, 2);
      run(1, 0, 80);
      // Untailed encoder: state must be cleared after in_last.
      sel = 1'b1;
      got.delete();
      add_frame(16'b11, 2);
      add_frame(16'b1, 1);
      run(0, 0, 50);
      chk("t4_count", 3'(got.size()), 3'd3);
      for (int i = 0; i < 3 && i < got.size(); i++) chk("t4_sym", got[i], t4[i]);
      // Mid-frame reset, then a fresh single-zero frame.
      sel = 1'b0;
      add_frame(16'b1011, 4);
      run(0, 2, 50);
      do_reset();
      got.delete();
      add_frame(16'b0, 1);
      run(0, 0, 50);
      chk("t5_count", 3'(got.size()), 3'd3);
      for (int i = 0; i < 3 && i < got.size(); i++) chk("t5_sym", got[i], 2'b00);
      for (int k = 0; k < 40; k++) begin
         sel = 1'($urandom % 2);
         for (int f = 0; f < 1 + int'($urandom % 3); f++) add_frame(16'($urandom), 1 + int'($urandom % 8));
         run(2, 0, 600);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/conv_encoder_k3.md
Name: conv_encoder_k3

Overview:
Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder's branch-metric and ACS path. It accepts one information bit per handshake and emits one 2-bit code symbol per handshake, using the same bit pairing that the decoder expects on rx_pair. At the end of each frame it appends K-1 = 2 zero tail bits so the trellis terminates in state 00.

Parameters:
G0, 3'b111, generator polynomial for out_pair[1]; bit 2 taps the current input, bit 0 taps the oldest stored bit.
G1, 3'b101, generator polynomial for out_pair[0]; same tap ordering as G0.
TAIL_EN, 1, 1 = append 2 zero tail bits after in_last; 0 = no tail.

Ports:
clk  input  1  single clock; all logic on its rising edge.
rst_n  input  1  reset, synchronous, active-low.
in_valid  input  1  information bit present.
in_bit  input  1  information bit.
in_last  input  1  marks the final information bit of the frame; qualified by in_valid.
in_ready  output  1  encoder can accept a bit this cycle.
out_valid  output  1  code symbol present.
out_pair  output  2  code symbol; [1] = G0 parity, [0] = G1 parity.
out_last  output  1  final symbol of the frame (the last tail symbol, or the data symbol when TAIL_EN=0).
out_ready  input  1  downstream accepts the symbol.
busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state register s = 2'b00, FSM = IDLE.
  - out_valid = 0, out_pair = 2'b00, out_last = 0, busy = 0.
  - A reset asserted mid-frame or mid-tail aborts the frame immediately. No further symbols are emitted.
- Encoder register:
  - s = {s1, s0}, where s1 is the most recent input and s0 is the one before it.
  - Let r = {u, s1, s0}, where u is the current input bit.
  - out_pair[1] = ^(G0 & r); out_pair[0] = ^(G1 & r).
  - Next state s = {u, s1}.
- Output register:
  - There is a single output stage.
  - "Slot free" is defined as slot_free = !out_valid || out_ready.
  - While out_valid=1 and out_ready=0, out_pair and out_last hold stable.
  - A load and a drain may happen in the same cycle. This gives full throughput of 1 symbol per clock.
- Latency: an input accepted at edge N produces its symbol with out_valid=1 in the cycle after edge N (1-cycle latency).
- FSM states are IDLE, DATA, TAIL1, TAIL2.
- IDLE / DATA:
  - in_ready = slot_free.
  - A bit is accepted when in_valid && in_ready: it is encoded and loaded, and s is updated.
  - First accept moves IDLE to DATA.
  - Accept with in_last=1 and TAIL_EN=1 moves to TAIL1.
  - Accept with in_last=1 and TAIL_EN=0 sets out_last=1 on that symbol, forces s = 00 and moves to IDLE.
- TAIL1:
  - in_ready = 0.
  - When slot_free, encode u=0, load the symbol with out_last=0, update s and move to TAIL2.
- TAIL2:
  - in_ready = 0.
  - When slot_free, encode u=0, load the symbol with out_last=1 and move to IDLE.
  - s is 00 by construction after this step.
- Back-to-back frames: a new frame may be accepted in the IDLE cycle immediately after the TAIL2 load, provided slot_free.
- in_bit and in_last are ignored when in_valid=0. They are also ignored whenever in_ready=0.
- busy = (FSM != IDLE).

Test Plan:
1. Reset, then send bits 1,0,1,1 (in_last on the 4th) with out_ready held at 1 and TAIL_EN=1 -> out_pair sequence 11,10,00,01,01,11 on consecutive cycles; out_last=1 only on the 6th symbol; busy falls afterwards.
2. Repeat scenario 1 while toggling out_ready 1,0,0,1,... -> identical symbol sequence; out_pair is stable during every stall; in_ready=0 whenever out_valid && !out_ready.
3. Two frames back to back, [1] then [1,1] -> symbols 11,10,11 then 11,01,01,11 with no idle gap; in_ready is 0 during both tail cycles of each frame.
4. TAIL_EN=0, bits 1,1 with in_last on the second -> symbols 11,01 with out_last on the second; the next frame's bit 1 produces 11, proving the state was cleared to 00.
5. Assert rst_n=0 for one cycle after 2 data bits of a frame -> out_valid=0 next cycle, FSM returns to IDLE; a new single-bit frame [0] yields 00,00,00.
6. Hold in_valid=1 while in TAIL1/TAIL2 -> no bits are consumed; the first data symbol of the next frame appears only after the out_last symbol.
